// File: rtl/sram_burst_reader.sv
// Burst reader: streams cfg_len consecutive SRAM words (address wraps) into a
// valid/ready output through a 3-entry skid FIFO sized for the 1-cycle read latency.
module sram_burst_reader #(
  parameter int ABITS = 9,
  parameter int DBITS = 32
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ABITS-1:0] cfg_addr,
  input  logic [ABITS:0]   cfg_len,
  output logic [ABITS-1:0] A,
  output logic             CE,
  output logic             WE,
  output logic [DBITS-1:0] WEM,
  input  logic [DBITS-1:0] Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  typedef struct packed {
    logic             last;
    logic [DBITS-1:0] data;
  } entry_t;

  state_t           state, state_nx;
  logic [ABITS-1:0] addr_q;
  logic [ABITS:0]   rem_q;
  logic             inflight, inflight_last;
  entry_t           fifo [3];
  logic [1:0]       wptr, rptr, occ;
  logic [2:0]       pend;
  logic             accept, ce, push, pop, done_nx;
  entry_t           head;

  assign head      = fifo[rptr];
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid & head.last;
  assign cfg_ready = (state == IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign push      = inflight;
  assign pop       = out_valid & out_ready;
  // Words already buffered plus the one on its way back from the SRAM.
  assign pend      = {1'b0, occ} + {2'b0, inflight};
  assign A         = addr_q;
  assign CE        = ce;
  assign WE        = 1'b0;
  assign WEM       = '0;

  always_comb begin
    state_nx = state;
    ce       = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && cfg_len != '0) state_nx = READ;
        if (accept && cfg_len == '0) done_nx  = 1'b1;
      end
      READ: begin
        ce = (pend < 3'd3);
        if (ce && rem_q == (ABITS+1)'(1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      done          <= done_nx;
      inflight      <= ce;
      inflight_last <= ce && (rem_q == (ABITS+1)'(1));
      if (accept) begin
        addr_q <= cfg_addr;
        rem_q  <= cfg_len;
      end else if (ce) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 3; i++) fifo[i] <= '0;
      wptr <= 2'd0;
      rptr <= 2'd0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        fifo[wptr] <= '{last: inflight_last, data: Q};
        wptr       <= (wptr == 2'd2) ? 2'd0 : wptr + 2'd1;
      end
      if (pop) rptr <= (rptr == 2'd2) ? 2'd0 : rptr + 2'd1;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/sram_burst_reader.md
SRAM_BURST_READER -- requirements
Module: sram_burst_reader

Interface
REQ-001: The block SHALL have parameter ABITS, default 9, meaning the SRAM address width.
REQ-002: The block SHALL have parameter DBITS, default 32, meaning the SRAM data width.
REQ-003: The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- CLK  in  1  clock; all logic on its rising edge.
- RSTN  in  1  asynchronous active-low reset.
REQ-004: Configuration port:
- cfg_valid  in  1  burst request.
- cfg_ready  out  1  block can accept a request.
- cfg_addr  in  ABITS  start word address.
- cfg_len  in  ABITS+1  burst length in words, 0..2^ABITS.
REQ-005: SRAM read port:
- A  out  ABITS  SRAM address.
- CE  out  1  SRAM port enable.
- WE  out  1  write enable; constant 0.
- WEM  out  DBITS  write mask; constant 0.
- Q  in  DBITS  SRAM read data, valid the cycle after CE.
REQ-006: Output stream:
- out_valid  out  1  word available.
- out_ready  in  1  sink accepts the word.
- out_data  out  DBITS  read word.
- out_last  out  1  marks the final word of the burst.
- done  out  1  one-cycle end-of-burst pulse.

Function
REQ-007: States SHALL be IDLE, READ and DRAIN; cfg_ready SHALL be 1 only in IDLE.
REQ-008: A request SHALL be accepted when cfg_valid and cfg_ready are both 1 in cycle T.
- cfg_len = 0: done SHALL pulse in T+1, there SHALL be no SRAM access, and the state SHALL stay IDLE.
- cfg_len > 0: the state SHALL go to READ.
REQ-009: In READ, CE SHALL be 1 in a cycle exactly when occ + inflight < 3, where:
- occ = output buffer occupancy;
- inflight = 1 if CE was 1 in the previous cycle, else 0.
REQ-010: The first CE SHALL occur in T+1 with A = cfg_addr; each subsequent CE SHALL use the previous A + 1, modulo 2^ABITS (511 wraps to 0).
REQ-011: Q SHALL be written into a 3-entry FIFO at the end of the cycle following CE, so out_valid rises 2 cycles after CE (first word in T+3).
REQ-012: After issuing cfg_len reads, the state SHALL go to DRAIN with CE = 0 until the FIFO is empty.
REQ-013: With out_ready held at 1, the block SHALL sustain one word per cycle with no bubbles after the first word.
REQ-014: Words SHALL leave the FIFO in address order on each out_valid and out_ready handshake.
- out_data and out_valid SHALL be held stable while out_ready = 0.
- The FIFO SHALL never overflow.
REQ-015: out_last SHALL be 1 exactly on the cfg_len-th word of the burst.
REQ-016: done SHALL pulse the cycle after the out_last handshake; the state SHALL return to IDLE in that same cycle, with cfg_ready = 1.
REQ-017: A simultaneous FIFO push and pop SHALL leave occ unchanged.
REQ-018: cfg_valid SHALL be ignored outside IDLE.
REQ-019: cfg_len = 2^ABITS SHALL read every address once, wrapping as needed.
REQ-020: The outputs WE and WEM SHALL be constant 0 in every state, including reset.

Reset
REQ-021: While RSTN = 0, independent of CLK, the block SHALL hold:
- state = IDLE, with cfg_ready = 1;
- CE = 0, A = 0;
- out_valid = 0, out_last = 0, out_data = 0, done = 0;
- FIFO empty, inflight = 0.
REQ-022: Reset asserted mid-burst SHALL abort the burst and discard buffered and in-flight words.
- After deassertion, no stale word SHALL appear.
- The first rising edge after deassertion SHALL behave as an IDLE cycle.

Verification
REQ-023: addr=0x010, len=4, out_ready=1 accepted in T:
- CE=1 in T+1..T+4 with A=0x010..0x013;
- out_valid in T+3..T+6 carrying mem[0x010..0x013], out_last in T+6;
- done in T+7.
REQ-024: addr=0x1FE, len=4: A SHALL be 0x1FE, 0x1FF, 0x000, 0x001 and data SHALL match those locations.
REQ-025: len=8, out_ready=0 from the first out_valid for 10 cycles:
- at most 3 words outstanding;
- CE=0 while occ+inflight=3;
- all 8 words delivered in order, with none lost or duplicated after out_ready rises.
REQ-026: len=0: cfg accepted, done in the next cycle, CE never asserted, out_valid never asserted.
REQ-027: RSTN pulled low while 2 words are buffered:
- outputs cleared immediately, with no clock edge needed;
- next burst addr=0x100, len=2 returns only mem[0x100] and mem[0x101].
REQ-028: Random out_ready (50%) with len=512 from addr=0x0AB:
- all 512 words in wrap order;
- exactly one out_last and one done pulse;
- WE and WEM = 0 throughout.
